// File: rtl/sc_stream_counter.sv
// rtl/sc_stream_counter.sv - counts ones per WINDOW valid stochastic samples
// and holds each window count in a single-entry valid/ready output register.
module sc_stream_counter #(
  parameter int WINDOW      = 256,
  parameter int COUNT_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_bit,
  input  logic                   in_valid,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST_SAMP = CW'(WINDOW - 1);

  logic [CW-1:0]          samp_cnt_q, samp_cnt_d;
  logic [CW-1:0]          ones_cnt_q, ones_cnt_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   handshake;
  logic                   window_done;
  logic [COUNT_WIDTH-1:0] final_count;

  assign handshake   = out_valid_q && out_ready;
  assign window_done = in_valid && (samp_cnt_q == LAST_SAMP);
  // Widen before adding: a window of all ones yields WINDOW, one past ones_cnt's range.
  assign final_count = COUNT_WIDTH'(ones_cnt_q) + COUNT_WIDTH'(in_bit);

  always_comb begin
    samp_cnt_d  = samp_cnt_q;
    ones_cnt_d  = ones_cnt_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (window_done) begin
      samp_cnt_d = '0;
      ones_cnt_d = '0;
      // A slot freed by this cycle's handshake can take the new count immediately.
      if (!out_valid_q || handshake) begin
        out_count_d = final_count;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (in_valid) begin
      samp_cnt_d = samp_cnt_q + 1'b1;
      ones_cnt_d = ones_cnt_q + CW'(in_bit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q  <= '0;
      ones_cnt_q  <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      samp_cnt_q  <= samp_cnt_d;
      ones_cnt_q  <= ones_cnt_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (samp_cnt_q != '0);

endmodule
